// File: rtl/x25519_pkg.sv
// Shared widths, ladder-state types and sequencer states for the X25519 core.
// X25519_CLAMP_EN selects whether the scalar is clamped on load.
package x25519_pkg;

    localparam int FIELD_W     = 256;
    localparam int PAD_W       = 264;
    localparam int LADDER_BITS = 255;
    localparam int POS_W       = 8;

    localparam logic [POS_W-1:0] POS_TOP = POS_W'(LADDER_BITS - 1);

    typedef struct packed {
        logic [FIELD_W-1:0] z;
        logic [FIELD_W-1:0] x;
    } xz_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_LAUNCH,
        ST_WAIT,
        ST_DONE
    } seq_state_e;

    // RFC 7748 clamp: clear bits 0..2 and 255, set bit 254.
    function automatic logic [FIELD_W-1:0] clamp_scalar(input logic [FIELD_W-1:0] e);
        logic [FIELD_W-1:0] r;
        r        = e;
        r[2:0]   = 3'b000;
        r[255]   = 1'b0;
        r[254]   = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/x25519_ladder_bit_source.sv
// Scalar register and bit-position down-counter feeding the ladder bit b.
// X25519_CLAMP_EN defined: the scalar is clamped as it is loaded.
module x25519_ladder_bit_source
    import x25519_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic               step_i,
    input  logic [FIELD_W-1:0] scalar_i,
    output logic               bit_o,
    output logic               last_o
);

    logic [FIELD_W-1:0] e_q;
    logic [FIELD_W-1:0] e_d;
    logic [POS_W-1:0]   pos_q;

    always_comb begin
`ifdef X25519_CLAMP_EN
        e_d = clamp_scalar(scalar_i);
`else
        e_d = scalar_i;
`endif
    end

    // The zero test guards the decrement so pos never wraps past bit 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_q   <= '0;
            pos_q <= '0;
        end else if (load_i) begin
            e_q   <= e_d;
            pos_q <= POS_TOP;
        end else if (step_i && (pos_q != '0)) begin
            pos_q <= pos_q - 1'b1;
        end
    end

    assign bit_o  = e_q[pos_q];
    assign last_o = (pos_q == '0);

endmodule

// File: rtl/x25519_ladder_sequencer.sv
// Montgomery-ladder control loop: walks scalar bits 254..0, launching one iteration per bit.
// X25519_CLAMP_EN (in the bit source) enables scalar clamping on load.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | operands latched, first launch being armed
// LAUNCH | iter_en high for one cycle
// WAIT   | waiting for iter_valid from the iteration stage
// DONE   | done pulse, result on xz_out
module x25519_ladder_sequencer
    import x25519_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [FIELD_W-1:0] scalar,
    input  logic [FIELD_W-1:0] point_u,
    output logic               busy,
    output logic               done,
    output logic [511:0]       xz_out,
    output logic               iter_en,
    output logic               iter_b,
    output logic [511:0]       iter_xzm,
    output logic [511:0]       iter_xzm1,
    output logic [PAD_W-1:0]   iter_work_low,
    input  logic               iter_valid,
    input  logic [511:0]       iter_xzm_in,
    input  logic [511:0]       iter_xzm1_in
);

    seq_state_e         state_q;
    xz_t                xzm_q;
    xz_t                xzm1_q;
    xz_t                xz_out_q;
    logic [FIELD_W-1:0] u_q;
    logic               busy_q;
    logic               done_q;
    logic               iter_en_q;

    logic               load;
    logic               step;
    logic               last;

    assign load = (state_q == ST_IDLE) && start;
    assign step = (state_q == ST_WAIT) && iter_valid;

    x25519_ladder_bit_source u_bit_source (
        .clk      (clk),
        .rst      (rst),
        .load_i   (load),
        .step_i   (step),
        .scalar_i (scalar),
        .bit_o    (iter_b),
        .last_o   (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            xzm_q     <= '0;
            xzm1_q    <= '0;
            xz_out_q  <= '0;
            u_q       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            iter_en_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            iter_en_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        u_q     <= point_u;
                        xzm_q   <= xz_t'{z: '0, x: FIELD_W'(1)};
                        xzm1_q  <= xz_t'{z: FIELD_W'(1), x: point_u};
                        busy_q  <= 1'b1;
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    iter_en_q <= 1'b1;
                    state_q   <= ST_LAUNCH;
                end
                ST_LAUNCH: begin
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (iter_valid) begin
                        xzm_q  <= iter_xzm_in;
                        xzm1_q <= iter_xzm1_in;
                        if (last) begin
                            xz_out_q <= iter_xzm_in;
                            done_q   <= 1'b1;
                            state_q  <= ST_DONE;
                        end else begin
                            // Relaunch straight from here so the next iter_en lands at iter_valid+1.
                            iter_en_q <= 1'b1;
                            state_q   <= ST_LAUNCH;
                        end
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign xz_out        = xz_out_q;
    assign iter_en       = iter_en_q;
    assign iter_xzm      = xzm_q;
    assign iter_xzm1     = xzm1_q;
    assign iter_work_low = {8'h00, u_q};

endmodule

// File: tb/tb_x25519_ladder_sequencer.sv
// Bench for x25519_ladder_sequencer with a fixed-latency-5 stub iteration stage.
module tb_x25519_ladder_sequencer;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [255:0]   scalar = '0;
    logic [255:0]   point_u = '0;
    logic           busy;
    logic           done;
    logic [511:0]   xz_out;
    logic           iter_en;
    logic           iter_b;
    logic [511:0]   iter_xzm;
    logic [511:0]   iter_xzm1;
    logic [263:0]   iter_work_low;
    logic           iter_valid;
    logic [511:0]   iter_xzm_in;
    logic [511:0]   iter_xzm1_in;

    logic           stub_valid = 1'b0;
    logic [511:0]   stub_xzm = '0;
    logic [511:0]   stub_xzm1 = '0;
    logic           inj_valid = 1'b0;
    logic [511:0]   inj_xzm = '0;
    logic [511:0]   inj_xzm1 = '0;

    assign iter_valid   = stub_valid | inj_valid;
    assign iter_xzm_in  = stub_valid ? stub_xzm : inj_xzm;
    assign iter_xzm1_in = stub_valid ? stub_xzm1 : inj_xzm1;

    always #5 clk = ~clk;

    x25519_ladder_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .scalar        (scalar),
        .point_u       (point_u),
        .busy          (busy),
        .done          (done),
        .xz_out        (xz_out),
        .iter_en       (iter_en),
        .iter_b        (iter_b),
        .iter_xzm      (iter_xzm),
        .iter_xzm1     (iter_xzm1),
        .iter_work_low (iter_work_low),
        .iter_valid    (iter_valid),
        .iter_xzm_in   (iter_xzm_in),
        .iter_xzm1_in  (iter_xzm1_in)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stub iteration stage: returns xzm+1, xzm1+2 five cycles after each launch.
    int           dly = 0;
    logic [511:0] lat_xzm = '0;
    logic [511:0] lat_xzm1 = '0;
    always @(negedge clk) begin
        stub_valid = 1'b0;
        if (rst) begin
            dly = 0;
        end else begin
            if (dly > 0) begin
                dly = dly - 1;
                if (dly == 0) begin
                    stub_valid = 1'b1;
                    stub_xzm   = lat_xzm + 512'd1;
                    stub_xzm1  = lat_xzm1 + 512'd2;
                end
            end
            if (iter_en) begin
                dly      = 5;
                lat_xzm  = iter_xzm;
                lat_xzm1 = iter_xzm1;
            end
        end
    end

    // Per-run monitor; a run begins when start is seen while the block is idle.
    int           run_en = 0, run_ones = 0, run_done = 0, work_bad = 0;
    int           start_cyc = 0, first_cyc = 0, done_cyc = 0;
    logic         first_b = 1'b0, last_b = 1'b0, b55 = 1'b0;
    logic [511:0] last_xzm1 = '0;
    logic [255:0] cur_u = '0;
    always @(negedge clk) begin
        if (!rst && start && !busy) begin
            run_en = 0; run_ones = 0; run_done = 0; work_bad = 0;
            start_cyc = cyc; cur_u = point_u;
        end
        if (iter_en) begin
            run_en = run_en + 1;
            if (run_en == 1) begin
                first_cyc = cyc;
                first_b   = iter_b;
            end
            if (run_en == 55) b55 = iter_b;
            if (iter_b) run_ones = run_ones + 1;
            last_b    = iter_b;
            last_xzm1 = iter_xzm1;
            if (iter_work_low !== {8'h00, cur_u}) work_bad = work_bad + 1;
        end
        if (done) begin
            run_done = run_done + 1;
            done_cyc = cyc;
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_start(input logic [255:0] s, input logic [255:0] u);
        @(posedge clk); #1;
        scalar = s; point_u = u; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (run_done > 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_busy"}, 512'(busy), 512'd0);
        chk({tag, "_done"}, 512'(done), 512'd0);
        chk({tag, "_iter_en"}, 512'(iter_en), 512'd0);
        chk({tag, "_iter_b"}, 512'(iter_b), 512'd0);
        chk({tag, "_xz_out"}, xz_out, 512'd0);
        chk({tag, "_iter_xzm"}, iter_xzm, 512'd0);
        chk({tag, "_iter_xzm1"}, iter_xzm1, 512'd0);
        chk({tag, "_work_low"}, 512'(iter_work_low), 512'd0);
    endtask

    typedef struct {
        logic [255:0] scalar;
        logic [255:0] u;
        int           ones;
        logic         first_b;
        logic         last_b;
        logic         b55;
    } vec_t;

    vec_t vecs[4];

    task automatic run_case(input int k);
        logic         ok;
        logic [511:0] exp_xzm1;
        string        t;
        t = $sformatf("v%0d", k);
        exp_xzm1 = ((512'd1 << 256) | 512'(vecs[k].u)) + 512'd508;
        do_start(vecs[k].scalar, vecs[k].u);
        wait_done(2000, ok);
        chk({t, "_done_seen"}, 512'(ok), 512'd1);
        chk({t, "_pulses"}, 512'(run_en), 512'd255);
        chk({t, "_ones"}, 512'(run_ones), 512'(vecs[k].ones));
        chk({t, "_first_b"}, 512'(first_b), 512'(vecs[k].first_b));
        chk({t, "_last_b"}, 512'(last_b), 512'(vecs[k].last_b));
        chk({t, "_b55"}, 512'(b55), 512'(vecs[k].b55));
        chk({t, "_first_en_lat"}, 512'(first_cyc - start_cyc), 512'd2);
        chk({t, "_done_lat"}, 512'(done_cyc - start_cyc), 512'd1532);
        chk({t, "_xz_out"}, xz_out, 512'd256);
        chk({t, "_last_xzm1"}, last_xzm1, exp_xzm1);
        chk({t, "_work_low"}, 512'(work_bad), 512'd0);
        repeat (2) @(posedge clk);
        #1;
        chk({t, "_busy_after"}, 512'(busy), 512'd0);
        chk({t, "_done_count"}, 512'(run_done), 512'd1);
    endtask

    initial begin
        logic         ok;
        int           snap;
        logic [255:0] ones256;
        ones256 = '1;

`ifdef X25519_CLAMP_EN
        vecs[0] = '{256'd1 << 200, 256'd9, 2, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{ones256, ones256, 252, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{256'd0, 256'd9, 1, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{(256'd1 << 255) | 256'd1, 256'h1234_5678, 1, 1'b1, 1'b0, 1'b0};
`else
        vecs[0] = '{256'd1 << 200, 256'd9, 1, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{ones256, ones256, 255, 1'b1, 1'b1, 1'b1};
        vecs[2] = '{256'd0, 256'd9, 0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{(256'd1 << 255) | 256'd1, 256'h1234_5678, 1, 1'b0, 1'b1, 1'b0};
`endif

        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_zero_outputs("idle");

        for (int k = 0; k < 4; k++) run_case(k);

        // Start while busy (10th launch) and start coinciding with the final iter_valid.
        do_start(256'd1 << 200, 256'd5);
        for (int i = 0; i < 200 && run_en < 10; i++) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 2000 && run_en < 255; i++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(100, ok);
        chk("sb_done_seen", 512'(ok), 512'd1);
        chk("sb_done_lat", 512'(done_cyc - start_cyc), 512'd1532);
        repeat (8) @(posedge clk);
        #1;
        chk("sb_pulses", 512'(run_en), 512'd255);
        chk("sb_done_count", 512'(run_done), 512'd1);
        chk("sb_busy_after", 512'(busy), 512'd0);
        chk("sb_xz_out", xz_out, 512'd256);

        // Reset mid-run, then a stray iter_valid while idle.
        do_start(ones256, 256'd7);
        for (int i = 0; i < 1000 && run_en < 100; i++) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check_zero_outputs("midrst");
        rst = 1'b0;
        snap = run_en;
        @(posedge clk); #1;
        inj_valid = 1'b1;
        inj_xzm   = {8{64'hdead_beef_cafe_f00d}};
        inj_xzm1  = {8{64'h0123_4567_89ab_cdef}};
        @(posedge clk); #1;
        inj_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_zero_outputs("stray");
        chk("stray_no_launch", 512'(run_en), 512'(snap));

        run_case(0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/x25519_ladder_sequencer.md
# x25519_ladder_sequencer

Scalar-multiplication control loop for the X25519 core. The block sits directly upstream of the Montgomery-ladder iteration stage. It holds the scalar and base-point u-coordinate, and for each scalar bit from 254 down to 0 it presents the current ladder state (xzm, xzm1), the bit b and the work operand. It launches one iteration, captures the returned state, and repeats. After the last bit it hands the projective result {z, x} downstream to the inversion/final-multiply stage.

## Interface
Parameters:
- none; all widths are fixed by the field size and come from the shared package.

Ports:
- clk  in  1  core clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- scalar  in  256  little-endian scalar e; sampled on accepted start.
- point_u  in  256  base-point u-coordinate; sampled on accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse; xz_out is valid from this cycle.
- xz_out  out  512  final xzm: [255:0]=x, [511:256]=z; held until the next accepted start.
- iter_en  out  1  one-cycle launch pulse to the iteration stage.
- iter_b  out  1  current scalar bit.
- iter_xzm  out  512  current xzm.
- iter_xzm1  out  512  current xzm1.
- iter_work_low  out  264  {8'h0, u}.
- iter_valid  in  1  iteration result strobe.
- iter_xzm_in  in  512  returned xzm; captured on iter_valid.
- iter_xzm1_in  in  512  returned xzm1; captured on iter_valid.

## Operation
- Reset values: every output and register is 0, and the state is IDLE.
- IDLE: on start, latch the scalar (clamped when configured) and u. Initialise:
  - xzm = {z=0, x=1}
  - xzm1 = {z=1, x=u}
  - pos = 254
  - next state: LAUNCH
- LAUNCH: drive iter_en=1 for exactly one cycle, with iter_b = e[pos]. Next state: WAIT.
- WAIT: on iter_valid, capture iter_xzm_in/iter_xzm1_in into xzm/xzm1.
  - If pos==0: copy the captured xzm to xz_out and go to DONE.
  - Otherwise: decrement pos and go to LAUNCH.
- DONE: pulse done for one cycle, then go to IDLE.
- iter_b, iter_xzm, iter_xzm1 and iter_work_low are stable from the iter_en cycle until the matching iter_valid, because the iteration stage reads them after launch.
- pos is an 8-bit down-counter. It never wraps: the 0 test precedes the decrement. There are exactly 255 iterations.
- start while busy is ignored; it is neither queued nor a restart.
- iter_valid in any state other than WAIT is ignored, with no capture.
- start and a final iter_valid in the same cycle: the final result completes normally and that start is dropped.
- Reset asserted mid-run aborts immediately. All outputs return to 0, the iteration stage is simply abandoned, and its later iter_valid is ignored in IDLE.
- No arithmetic is done here; values pass through unmodified except for the zero-extension of work to 264 bits.

## Timing
- Accepted start at cycle S. First iter_en at S+2 (S+1 latch, S+2 LAUNCH).
- Iteration latency L means iter_valid arrives at launch+L. The next iter_en follows at iter_valid+1.
- done at final iter_valid+1, then busy drops in the cycle after done.
- Total latency from start to done: 2 + 255*(L+1). Next start is accepted from done+1.

## Configuration
- X25519_CLAMP_EN defined: the latched scalar is clamped per RFC 7748. Bits 0, 1, 2 and 255 are cleared and bit 254 is set.
- X25519_CLAMP_EN undefined: the scalar is latched verbatim, and the caller clamps.

## Structure
- x25519_pkg holds:
  - the field width constant (256)
  - the padded width (264)
  - the ladder bit count (255)
  - a packed struct xz_t {z, x}
  - the sequencer state enum
- The natural sub-module is x25519_ladder_bit_source. It contains the scalar register, optional clamp, pos counter and iter_b mux, and exposes load/step/last. The FSM and state registers stay in the top.

## Test plan
Run all scenarios against a fixed-latency-5 stub iteration model.
- Bit order: scalar=256'h1 << 200, clamp off. Exactly 255 iter_en pulses; iter_b=1 only on the 55th pulse; done at start+2+255*6=start+1532.
- Clamp: scalar all-ones with X25519_CLAMP_EN. iter_b is 1 for pos 254..3 and 0 for pos 2..0. Without the macro, all iter_b=1.
- Data path: stub returns xzm_in=xzm+1, xzm1_in=xzm1+2. Final xz_out = {z=0, x=1}+255; iter_xzm1 at the last launch = initial+508; iter_work_low={8'h0, u}.
- Start-while-busy: pulse start at the 10th iter_en. The iteration count stays 255 and done pulses once.
- Reset mid-run: assert rst at iteration 100, then inject a stray iter_valid. Outputs stay 0 and state stays IDLE. A new start then runs the full 255.
- Real-stage smoke: with the real iteration stage connected, scalar=0 and u=9 give xz_out with z=0 and x≡1 mod p.
